uart_fsm_tx: RTL and testbench

- UART serial transmitter built around a Moore state machine.
- On a start request it latches an 8-bit byte and shifts it out on tx as one frame: start bit, 8 data bits LSB first, optional parity, then stop bit(s), each bit lasting a fixed number of clocks.
- Pulses Done when the frame completes.
- Sits between a byte producer (controller/FIFO) and the serial TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 43 ++++
 rtl/uart_fsm_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_fsm_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// Holds the FSM state encoding, frame geometry, default baud constants and the parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CLK_HZ    = 100_000_000;
    localparam int BAUD      = 9600;
    // Rounded to the nearest clock so the bit period error stays below half a clock.
    localparam int CLKS_PER_BIT_DEF = (CLK_HZ + (BAUD / 2)) / BAUD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_e;

    function automatic logic byte_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// Held at zero while clear is high so the first bit after clear is a full period.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap on the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/uart_fsm_tx.sv
// UART transmitter: Moore FSM framing a latched byte as start, data LSB first, optional parity, stop.
// tx, Done and x are all flops, so the line only moves on bit boundaries.
module uart_fsm_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] datain,
    input  logic       start,
    output logic       tx,
    output logic       Done,
    output logic       x
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        bit_done_s;
    logic        cnt_clear_s;

    // The timer only runs while a bit is on the line.
    assign cnt_clear_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (cnt_clear_s),
        .bit_done(bit_done_s)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    shift_d  = datain;
                    parity_d = byte_parity(datain) ^ PAR_SENSE;
                    idx_d    = 3'd0;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d = ST_STOP;
                    idx_d   = 3'd0;
                    tx_d    = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                // idx counts stop bits here.
                if (bit_done_s) begin
                    if (idx_q == LAST_STOP) begin
                        state_d = ST_DONE;
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
                tx_d = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= 8'h00;
            idx_q    <= 3'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign Done = done_q;
    assign x    = busy_q;

endmodule

// File: tb/tb_uart_fsm_tx.sv
// Scoreboard bench for uart_fsm_tx: dut0 is 8N1, dut1 is 8E2; both at 16 clocks per bit.
// Expected frames are hand-written bit vectors (bit k = k-th bit on the line, start bit first).
module tb_uart_fsm_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic [7:0] datain0, datain1;
    logic       tx0, done0, x0, tx1, done1, x1;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int          starts0[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          dc0 = 0;
    int          dc1 = 0;

    always #5 clk = ~clk;

    uart_fsm_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .datain(datain0), .start(start0),
        .tx(tx0), .Done(done0), .x(x0)
    );

    uart_fsm_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .datain(datain1), .start(start1),
        .tx(tx1), .Done(done1), .x(x1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0 === 1'b1) dc0 <= dc0 + 1;
        if (done1 === 1'b1) dc1 <= dc1 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {tx, Done, x}
    function automatic logic [2:0] obs(input int w);
        return (w == 0) ? {tx0, done0, x0} : {tx1, done1, x1};
    endfunction

    task automatic monitor(input int w);
        int          nb;
        logic [11:0] e;
        logic [11:0] bits;
        logic        have, stable, busy_ok, aborted;
        logic [2:0]  o;
        nb = (w == 0) ? 10 : 12;
        forever begin
            @(negedge clk);
            o = obs(w);
            if (reset !== 1'b1) begin
                have = 1'b0;
            end else if (o[2] === 1'b1) begin
                chk("idle_quiet", {30'd0, o[1:0]}, 32'd0);
            end else begin
                have = 1'b0;
                e    = 12'h000;
                if (w == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); have = 1'b1;
                end else if (w == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); have = 1'b1;
                end
                if (!have) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_frame: dut%0d started a frame, expected none (cycle %0d)", w, cyc);
                end
                if (w == 0) starts0.push_back(cyc);
                bits = 12'h000; stable = 1'b1; busy_ok = 1'b1; aborted = 1'b0;
                for (int n = 0; n < nb * CPB; n++) begin
                    if (n > 0) @(negedge clk);
                    o = obs(w);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (n % CPB == 0) bits[n / CPB] = o[2];
                    else if (o[2] !== bits[n / CPB]) stable = 1'b0;
                    if (o[1:0] !== 2'b01) busy_ok = 1'b0;
                end
                if (!aborted) begin
                    @(negedge clk); o = obs(w);
                    chk("done_pulse", {29'd0, o}, 32'd7);
                    @(negedge clk); o = obs(w);
                    chk("return_idle", {29'd0, o}, 32'd4);
                    chk("bit_stable", {31'd0, stable}, 32'd1);
                    chk("busy_flag", {31'd0, busy_ok}, 32'd1);
                    if (have) chk("frame_bits", {20'd0, bits}, {20'd0, e});
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic pulse0(input logic [7:0] d);
        datain0 = d; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic pulse1(input logic [7:0] d);
        datain1 = d; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_dc(input int w, input int target, input int limit);
        int i;
        i = 0;
        while (((w == 0) ? dc0 : dc1) < target && i < limit) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", (w == 0) ? dc0 : dc1, target);
    endtask

    initial begin
        int dc_before;
        int seen;
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; datain0 = 8'h00; datain1 = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_dut0", {29'd0, tx0, done0, x0}, 32'd4);
        chk("reset_dut1", {29'd0, tx1, done1, x1}, 32'd4);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_activity", dc0 + dc1, 32'd0);

        // Basic 8N1 frame of 0xAA.
        q0.push_back(12'h354);
        pulse0(8'hAA);
        wait_dc(0, 1, 400);

        // start and datain changes mid-frame must not disturb the frame or queue another.
        q0.push_back(12'h354);
        pulse0(8'hAA);
        repeat (50) @(negedge clk);
        pulse0(8'h55);
        wait_dc(0, 2, 400);
        repeat (200) @(negedge clk);
        chk("single_done", dc0, 32'd2);

        // Asynchronous reset during data bit 3 (0xC5 bit 3 is 0, so tx must jump high).
        q0.push_back(12'h38A);
        pulse0(8'hC5);
        repeat (68) @(negedge clk);
        chk("data_bit3", {31'd0, tx0}, 32'd0);
        dc_before = dc0;
        #2 reset = 1'b0;
        #1 chk("async_reset", {29'd0, tx0, done0, x0}, 32'd4);
        @(negedge clk);
        chk("reset_hold", {29'd0, tx0, done0, x0}, 32'd4);
        @(negedge clk);
        reset = 1'b1;
        q0.push_back(12'h38A);
        pulse0(8'hC5);
        wait_dc(0, dc_before + 1, 400);

        // start held high: three back-to-back frames of 0x01.
        starts0.delete();
        repeat (3) q0.push_back(12'h202);
        datain0 = 8'h01; start0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 1000 && seen < 3; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) seen++;
        end
        start0 = 1'b0;
        chk("b2b_frames", seen, 32'd3);
        repeat (20) @(negedge clk);
        chk("b2b_starts", starts0.size(), 32'd3);
        if (starts0.size() >= 3) begin
            chk("b2b_gap1", starts0[1] - starts0[0], 32'd162);
            chk("b2b_gap2", starts0[2] - starts0[1], 32'd162);
        end

        // Even parity with two stop bits.
        q1.push_back(12'hE0E);
        pulse1(8'h07);
        wait_dc(1, 1, 600);
        q1.push_back(12'hC06);
        pulse1(8'h03);
        wait_dc(1, 2, 600);

        repeat (30) @(negedge clk);
        chk("scoreboard0_empty", q0.size(), 32'd0);
        chk("scoreboard1_empty", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
